keyed_mux_lock_seq: RTL and testbench
=====================================

// Module: keyed_mux_lock_seq
// PURPOSE
//  Sequential, parametrised key-controlled mux lock for obfuscated benchmark netlists.
//  CH channels; each channel selects one of 2**SEL_W candidate wires using its own SEL_W key bits.
//  The key is shifted in serially under a valid/ready handshake, then committed atomically.
//  Outputs are forced to 0 until the first commit.
//  Sits between the original netlist's internal nets and the gates that consume the locked wires.
// PARAMETERS
//  CH      4   number of locked wires (mux channels)
//  SEL_W   2   key bits per channel; candidates per channel CAND = 2**SEL_W
//  KEY_LEN CH*SEL_W (derived, localparam) total key bits
// PORTS
//  clk        in   1             rising-edge clock
//  rst_n      in   1             asynchronous active-low reset
//  key_start  in   1             1-cycle pulse: begin (re)loading a key
//  key_bit    in   1             serial key data, LSB (channel 0, bit 0) first
//  key_valid  in   1             key_bit valid this cycle
//  key_ready  out  1             block accepts key_bit this cycle
//  cand_i     in   CH*CAND       candidate nets; channel c, candidate k at [c*CAND+k]
//  mux_o      out  CH            registered locked outputs
//  locked     out  1             1 until the first successful commit
//  key_done   out  1             1-cycle pulse on commit
//  key_err    out  1             1-cycle pulse on a rejected key (KEY_PARITY_EN only; tied 0 otherwise)
// BEHAVIOUR
//  Reset: state=IDLE; shadow/active key=0; bit counter=0; mux_o=0; locked=1; key_ready=0; key_done=0; key_err=0.
//  FSM states:
//   - IDLE: key_ready=0. key_start -> SHIFT, counter cleared.
//   - SHIFT: key_ready=1. Each key_valid&key_ready shifts key_bit into shadow[cnt]; cnt++.
//     When a bit is accepted with cnt==KEY_LEN-1 (or the parity bit with KEY_PARITY_EN) -> COMMIT.
//     key_start in SHIFT restarts: cnt=0, shadow untouched and fully overwritten later; no commit.
//   - COMMIT (1 cycle): key_ready=0; active<=shadow; locked<=0; key_done=1 -> ARMED.
//   - ARMED: key_ready=0. key_start -> SHIFT.
//  The active key is held unchanged during a reload until the next COMMIT, so there are no partial-key outputs.
//  Datapath: sel_c = active[c*SEL_W +: SEL_W]; mux_o[c] <= locked ? 0 : cand_i[c*CAND+sel_c].
//   - Latency: 1 cycle from cand_i to mux_o.
//   - The first cycle after COMMIT already uses the new key.
//  key_valid while key_ready=0: ignored, not stored.
//  key_start on the same cycle as the final accepted bit: commit wins; the start is dropped.
//  Async reset mid-shift or in ARMED: all state returns to reset values immediately; the key is lost and locked=1.
// CONFIGURATION
//  Macro KEY_PARITY_EN:
//   - Defined: SHIFT expects KEY_LEN+1 bits; the last bit is even parity over the key.
//     On mismatch: no commit, shadow discarded, key_err pulses 1 cycle, state -> ARMED if locked==0 else IDLE.
//     The active key and locked are unchanged.
//   - Undefined: exactly KEY_LEN bits; key_err tied 0; no parity logic.
// STRUCTURE
//  Package keyed_lock_pkg:
//   - state enum {IDLE,SHIFT,COMMIT,ARMED}
//   - function key_len(CH,SEL_W)
//   - localparam for counter width $clog2(KEY_LEN+2)
//  Sub-module keyed_mux_ch (one per channel, generate loop):
//   - inputs: SEL_W select, CAND candidates, locked
//   - output: registered mux_o bit
// TESTING (CH=4, SEL_W=2)
//  1. Reset, no key, cand_i=16'hFFFF -> mux_o=4'h0, locked=1, key_ready=0.
//  2. key_start, shift 8'b11_10_01_00 (ch0 sel=0..ch3 sel=3), cand_i=16'h8421
//     -> key_done pulse one cycle after bit 8; locked=0; next cycle mux_o=4'hF.
//  3. Armed with test-2 key, cand_i=16'h0000 -> mux_o=4'h0 after 1 cycle. Reload with all-zero key;
//     mux_o follows the old key until commit (cand_i=16'h0001 -> mux_o=4'h1), then the new key (mux_o=4'h1, ch1..3 pick cand 0).
//  4. key_valid gaps (valid every 3rd cycle) and key_start after 5 bits -> count restarts;
//     commit only after 8 further accepted bits.
//  5. rst_n asserted after 4 bits -> immediate mux_o=0, locked=1, state IDLE; subsequent full load works.
//  6. KEY_PARITY_EN: test-2 key with parity 0 -> commit.
//     Same key with parity 1 -> key_err pulse, no key_done, locked stays 1.

Source files
------------

// File: rtl/keyed_lock_pkg.sv
// ============================================================================
// Module      : keyed_lock_pkg
// Description : Shared types and helpers for the keyed mux lock. Provides the
//               controller state encoding, key-length and counter-width helpers,
//               and the default channel geometry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package keyed_lock_pkg;

  // Default geometry: four locked wires, four candidates each
  localparam int c_def_ch    = 4;
  localparam int c_def_sel_w = 2;

  // Key loader states, explicit 2-bit encoding
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2,
    ARMED  = 2'd3
  } state_t;

  // Total key bits for a given channel count and per-channel select width
  function automatic int key_len(input int ch, input int sel_w);
    return ch * sel_w;
  endfunction

  // Bit counter width; leaves room for an optional trailing parity bit
  function automatic int cnt_w(input int klen);
    return $clog2(klen + 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/keyed_mux_lock_seq_ch.sv
// ============================================================================
// Module      : keyed_mux_ch
// Description : One locked wire. Picks a candidate net by its key slice and
//               registers it; the output is held at 0 while the lock is closed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keyed_mux_ch #(
  parameter int SEL_W = 2,
  parameter int CAND  = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] sel,
  input  logic [CAND-1:0]  cand,
  input  logic             locked,
  output logic             mux_o
);

  // Registered candidate select, forced low until the first key commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_o <= 1'b0;
    end else begin
      mux_o <= locked ? 1'b0 : cand[sel];
    end
  end

endmodule

`default_nettype wire

// File: rtl/keyed_mux_lock_seq.sv
// ============================================================================
// Module      : keyed_mux_lock_seq
// Description : Key-controlled mux lock. A serial key is shifted into a shadow
//               register under valid/ready and committed atomically to the
//               active key that drives CH registered candidate muxes.
//               Optional feature macro: KEY_PARITY_EN (trailing even-parity bit
//               checked before commit; a bad key raises key_err).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keyed_mux_lock_seq
  import keyed_lock_pkg::*;
#(
  parameter int CH    = c_def_ch,
  parameter int SEL_W = c_def_sel_w
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     key_start,
  input  logic                     key_bit,
  input  logic                     key_valid,
  output logic                     key_ready,
  input  logic [CH*(2**SEL_W)-1:0] cand_i,
  output logic [CH-1:0]            mux_o,
  output logic                     locked,
  output logic                     key_done,
  output logic                     key_err
);

  localparam int CAND    = 2 ** SEL_W;
  localparam int KEY_LEN = key_len(CH, SEL_W);
  localparam int c_cnt_w = cnt_w(KEY_LEN);
`ifdef KEY_PARITY_EN
  localparam int c_last_idx = KEY_LEN;      // parity bit closes the frame
`else
  localparam int c_last_idx = KEY_LEN - 1;  // last key bit closes the frame
`endif

  state_t               r_state;
  logic [KEY_LEN-1:0]   r_shadow;
  logic [KEY_LEN-1:0]   r_active;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_locked;
  logic                 r_key_ready;
  logic                 r_key_done;

  logic                 w_accept;
  logic                 w_last;
  logic [KEY_LEN-1:0]   w_shadow_nxt;

  assign w_accept = key_valid & r_key_ready;
  assign w_last   = w_accept && (r_cnt == c_cnt_w'(c_last_idx));

  // Shadow key with the incoming bit merged at the current count
  always_comb begin
    w_shadow_nxt = r_shadow;
    for (int i = 0; i < KEY_LEN; i++) begin
      if (r_cnt == c_cnt_w'(i)) begin
        w_shadow_nxt[i] = key_bit;
      end
    end
  end

`ifdef KEY_PARITY_EN
  logic w_par_ok;
  logic r_key_err;
  // Even parity: key bits plus the parity bit must XOR to zero
  assign w_par_ok = ~(^r_shadow ^ key_bit);
  assign key_err  = r_key_err;
`else
  assign key_err  = 1'b0;
`endif

  // Key loader FSM. Commit-side registers are updated on the edge that enters
  // COMMIT, so key_done/locked are visible during COMMIT and the mux edge that
  // closes COMMIT already uses the new key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_shadow    <= '0;
      r_active    <= '0;
      r_cnt       <= '0;
      r_locked    <= 1'b1;
      r_key_ready <= 1'b0;
      r_key_done  <= 1'b0;
`ifdef KEY_PARITY_EN
      r_key_err   <= 1'b0;
`endif
    end else begin
      r_key_done <= 1'b0;
`ifdef KEY_PARITY_EN
      r_key_err  <= 1'b0;
`endif
      case (r_state)
        IDLE, ARMED: begin
          if (key_start) begin
            r_state     <= SHIFT;
            r_cnt       <= '0;
            r_key_ready <= 1'b1;
          end
        end
        SHIFT: begin
          if (w_last) begin
            // Final bit wins over a simultaneous key_start
            r_cnt       <= '0;
            r_key_ready <= 1'b0;
`ifdef KEY_PARITY_EN
            if (w_par_ok) begin
              r_active   <= r_shadow;
              r_locked   <= 1'b0;
              r_key_done <= 1'b1;
              r_state    <= COMMIT;
            end else begin
              r_shadow  <= '0;
              r_key_err <= 1'b1;
              r_state   <= r_locked ? IDLE : ARMED;
            end
`else
            r_shadow   <= w_shadow_nxt;
            r_active   <= w_shadow_nxt;
            r_locked   <= 1'b0;
            r_key_done <= 1'b1;
            r_state    <= COMMIT;
`endif
          end else if (key_start) begin
            // Restart: shadow is fully overwritten by the next frame
            r_cnt <= '0;
          end else if (w_accept) begin
            r_shadow <= w_shadow_nxt;
            r_cnt    <= r_cnt + 1'b1;
          end
        end
        COMMIT: begin
          r_state <= ARMED;
        end
        default: begin
          r_state     <= IDLE;
          r_key_ready <= 1'b0;
        end
      endcase
    end
  end

  assign key_ready = r_key_ready;
  assign locked    = r_locked;
  assign key_done  = r_key_done;

  // One registered mux per locked wire
  for (genvar c = 0; c < CH; c++) begin : g_ch
    keyed_mux_ch #(
      .SEL_W (SEL_W),
      .CAND  (CAND)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .sel    (r_active[c*SEL_W +: SEL_W]),
      .cand   (cand_i[c*CAND +: CAND]),
      .locked (r_locked),
      .mux_o  (mux_o[c])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_keyed_mux_lock_seq.sv
// ============================================================================
// Module      : tb_keyed_mux_lock_seq
// Description : Directed self-checking bench for keyed_mux_lock_seq (CH=4,
//               SEL_W=2). Build with KEY_PARITY_EN to cover the parity path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keyed_mux_lock_seq;

`ifdef KEY_PARITY_EN
  localparam int c_frame = 9;
`else
  localparam int c_frame = 8;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_start = 1'b0;
  logic        key_bit = 1'b0;
  logic        key_valid = 1'b0;
  logic        key_ready;
  logic [15:0] cand_i = 16'hFFFF;
  logic [3:0]  mux_o;
  logic        locked;
  logic        key_done;
  logic        key_err;

  int n_pass  = 0;
  int n_total = 0;

  keyed_mux_lock_seq #(.CH(4), .SEL_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_start (key_start),
    .key_bit   (key_bit),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .cand_i    (cand_i),
    .mux_o     (mux_o),
    .locked    (locked),
    .key_done  (key_done),
    .key_err   (key_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic frame_bit(input logic [7:0] key, input logic flip, input int i);
    if (i < 8) return key[3'(i)];
    return ^key ^ flip;
  endfunction

  task automatic start_load();
    key_start = 1'b1;
    tick();
    key_start = 1'b0;
  endtask

  // Back-to-back bits [from, to); optionally raise key_start with the last bit
  task automatic send_frame(input logic [7:0] key, input logic flip, input int from,
                            input int to, input logic start_on_last);
    for (int i = from; i < to; i++) begin
      key_valid = 1'b1;
      key_bit   = frame_bit(key, flip, i);
      key_start = (i == to - 1) ? start_on_last : 1'b0;
      tick();
    end
    key_valid = 1'b0;
    key_start = 1'b0;
  endtask

  // Bits [from, to) with key_valid on every third cycle
  task automatic send_frame_gap(input logic [7:0] key, input int from, input int to);
    for (int i = from; i < to; i++) begin
      key_valid = 1'b0;
      tick();
      tick();
      key_valid = 1'b1;
      key_bit   = frame_bit(key, 1'b0, i);
      tick();
    end
    key_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cand_i = 16'hFFFF;
    tick(); tick();
    n_total++; if (mux_o !== 4'h0) $display("FAIL rst_mux: got %h want 0", mux_o); else n_pass++;
    n_total++; if (locked !== 1'b1) $display("FAIL rst_locked: got %b want 1", locked); else n_pass++;
    n_total++; if (key_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", key_ready); else n_pass++;
    n_total++; if (key_done !== 1'b0) $display("FAIL rst_done: got %b want 0", key_done); else n_pass++;
    rst_n = 1'b1;
    key_valid = 1'b1; key_bit = 1'b1;
    tick(); tick();
    key_valid = 1'b0;
    n_total++; if (mux_o !== 4'h0) $display("FAIL idle_mux: got %h want 0", mux_o); else n_pass++;
    n_total++; if (key_ready !== 1'b0) $display("FAIL idle_ready: got %b want 0", key_ready); else n_pass++;
  endtask

  task automatic test_load();
    cand_i = 16'h8421;
    start_load();
    n_total++; if (key_ready !== 1'b1) $display("FAIL load_ready: got %b want 1", key_ready); else n_pass++;
    send_frame(8'hE4, 1'b0, 0, c_frame - 1, 1'b0);
    n_total++; if (key_done !== 1'b0) $display("FAIL load_early_done: got %b want 0", key_done); else n_pass++;
    send_frame(8'hE4, 1'b0, c_frame - 1, c_frame, 1'b0);
    n_total++; if (key_done !== 1'b1) $display("FAIL load_done: got %b want 1", key_done); else n_pass++;
    n_total++; if (locked !== 1'b0) $display("FAIL load_locked: got %b want 0", locked); else n_pass++;
    n_total++; if (key_err !== 1'b0) $display("FAIL load_err: got %b want 0", key_err); else n_pass++;
    n_total++; if (key_ready !== 1'b0) $display("FAIL load_commit_ready: got %b want 0", key_ready); else n_pass++;
    tick();
    n_total++; if (key_done !== 1'b0) $display("FAIL load_done_pulse: got %b want 0", key_done); else n_pass++;
    n_total++; if (mux_o !== 4'hF) $display("FAIL load_mux: got %h want F", mux_o); else n_pass++;
  endtask

  task automatic test_reload();
    cand_i = 16'h0000;
    tick();
    n_total++; if (mux_o !== 4'h0) $display("FAIL armed_mux0: got %h want 0", mux_o); else n_pass++;
    cand_i = 16'h8421;
    start_load();
    send_frame(8'h00, 1'b0, 0, 4, 1'b0);
    n_total++; if (mux_o !== 4'hF) $display("FAIL reload_old_key: got %h want F", mux_o); else n_pass++;
    send_frame(8'h00, 1'b0, 4, c_frame, 1'b0);
    n_total++; if (key_done !== 1'b1) $display("FAIL reload_done: got %b want 1", key_done); else n_pass++;
    tick();
    n_total++; if (mux_o !== 4'h1) $display("FAIL reload_new_8421: got %h want 1", mux_o); else n_pass++;
    cand_i = 16'h1111;
    tick();
    n_total++; if (mux_o !== 4'hF) $display("FAIL reload_new_1111: got %h want F", mux_o); else n_pass++;
    cand_i = 16'h0001;
    tick();
    n_total++; if (mux_o !== 4'h1) $display("FAIL reload_new_0001: got %h want 1", mux_o); else n_pass++;
  endtask

  task automatic test_gaps();
    cand_i = 16'h1248;
    key_valid = 1'b1; key_bit = 1'b1;
    tick(); tick();
    key_valid = 1'b0;
    tick();
    n_total++; if (mux_o !== 4'h8) $display("FAIL ignored_valid_mux: got %h want 8", mux_o); else n_pass++;
    start_load();
    send_frame_gap(8'hFF, 0, 5);
    start_load();
    n_total++; if (key_ready !== 1'b1) $display("FAIL restart_ready: got %b want 1", key_ready); else n_pass++;
    send_frame_gap(8'h1B, 0, c_frame - 1);
    n_total++; if (key_ready !== 1'b1) $display("FAIL gap_no_commit: got %b want 1", key_ready); else n_pass++;
    n_total++; if (mux_o !== 4'h8) $display("FAIL gap_old_key: got %h want 8", mux_o); else n_pass++;
    send_frame_gap(8'h1B, c_frame - 1, c_frame);
    n_total++; if (key_done !== 1'b1) $display("FAIL gap_done: got %b want 1", key_done); else n_pass++;
    tick();
    n_total++; if (mux_o !== 4'hF) $display("FAIL gap_mux: got %h want F", mux_o); else n_pass++;
  endtask

  task automatic test_commit_wins();
    cand_i = 16'h8421;
    start_load();
    send_frame(8'hE4, 1'b0, 0, c_frame, 1'b1);
    n_total++; if (key_done !== 1'b1) $display("FAIL cw_done: got %b want 1", key_done); else n_pass++;
    tick();
    n_total++; if (key_ready !== 1'b0) $display("FAIL cw_start_dropped: got %b want 0", key_ready); else n_pass++;
    n_total++; if (mux_o !== 4'hF) $display("FAIL cw_mux: got %h want F", mux_o); else n_pass++;
  endtask

  task automatic test_async_reset();
    cand_i = 16'h8421;
    start_load();
    send_frame(8'hE4, 1'b0, 0, 4, 1'b0);
    n_total++; if (mux_o !== 4'hF) $display("FAIL ar_pre_mux: got %h want F", mux_o); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (mux_o !== 4'h0) $display("FAIL ar_mux: got %h want 0", mux_o); else n_pass++;
    n_total++; if (locked !== 1'b1) $display("FAIL ar_locked: got %b want 1", locked); else n_pass++;
    n_total++; if (key_ready !== 1'b0) $display("FAIL ar_ready: got %b want 0", key_ready); else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
    n_total++; if (key_ready !== 1'b0) $display("FAIL ar_idle_ready: got %b want 0", key_ready); else n_pass++;
    start_load();
    send_frame(8'hE4, 1'b0, 0, c_frame, 1'b0);
    n_total++; if (key_done !== 1'b1) $display("FAIL ar_reload_done: got %b want 1", key_done); else n_pass++;
    tick();
    n_total++; if (mux_o !== 4'hF) $display("FAIL ar_reload_mux: got %h want F", mux_o); else n_pass++;
  endtask

`ifdef KEY_PARITY_EN
  task automatic test_parity();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    cand_i = 16'h8421;
    start_load();
    send_frame(8'hE4, 1'b1, 0, c_frame, 1'b0);
    n_total++; if (key_err !== 1'b1) $display("FAIL par_err: got %b want 1", key_err); else n_pass++;
    n_total++; if (key_done !== 1'b0) $display("FAIL par_no_done: got %b want 0", key_done); else n_pass++;
    n_total++; if (locked !== 1'b1) $display("FAIL par_locked: got %b want 1", locked); else n_pass++;
    tick();
    n_total++; if (key_err !== 1'b0) $display("FAIL par_err_pulse: got %b want 0", key_err); else n_pass++;
    n_total++; if (mux_o !== 4'h0) $display("FAIL par_mux: got %h want 0", mux_o); else n_pass++;
    n_total++; if (key_ready !== 1'b0) $display("FAIL par_ready: got %b want 0", key_ready); else n_pass++;
    start_load();
    send_frame(8'hE4, 1'b0, 0, c_frame, 1'b0);
    n_total++; if (key_done !== 1'b1) $display("FAIL par_good_done: got %b want 1", key_done); else n_pass++;
    tick();
    start_load();
    send_frame(8'h00, 1'b1, 0, c_frame, 1'b0);
    n_total++; if (key_err !== 1'b1) $display("FAIL par_armed_err: got %b want 1", key_err); else n_pass++;
    tick();
    n_total++; if (locked !== 1'b0) $display("FAIL par_armed_locked: got %b want 0", locked); else n_pass++;
    n_total++; if (mux_o !== 4'hF) $display("FAIL par_armed_mux: got %h want F", mux_o); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_reload();
    test_gaps();
    test_commit_wins();
    test_async_reset();
`ifdef KEY_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
